l2_cache_ctrl: RTL and testbench

- Direct-mapped, write-back, write-allocate L2 cache controller between the L1 cache and the main-memory model.
- Accepts whole-line read/write requests from L1, serves hits locally, and on a miss writes back a dirty victim then fetches the line through the memory handshake (read_L2_MEM/write_L2_MEM, ready_MEM_L2).

---
 rtl/l2_pkg.sv | 18 +
 rtl/l2_tag_store.sv | 51 +++++
 rtl/l2_cache_ctrl.sv | 174 +++++++++++++++++
 tb/tb_l2_cache_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_pkg.sv
// l2_pkg: shared constants and FSM state encoding for the L2 cache controller.
//   INDEX_W / TAG_W / LINE_W : default geometry (256 sets, 18-bit tag, 512-bit line)
//   WORD_W                   : word width inside a line
//   state_t                  : controller FSM states
package l2_pkg;
    localparam int INDEX_W = 8;
    localparam int TAG_W   = 18;
    localparam int LINE_W  = 512;
    localparam int WORD_W  = 32;

    typedef enum logic [2:0] {
        IDLE,
        COMPARE,
        WRITE_BACK,
        ALLOCATE,
        RESPOND
    } state_t;
endpackage

// File: rtl/l2_tag_store.sv
// l2_tag_store: per-set valid/dirty/tag state with hit compare.
//   clk, rstn      : clock, async active-low reset (clears valid and dirty)
//   i_idx          : read/compare set index
//   i_cmp_tag      : tag compared against the stored tag
//   o_hit          : valid & tag match at i_idx
//   o_valid/o_dirty/o_tag : stored state at i_idx (victim information)
//   i_we, i_wr_idx, i_wr_tag, i_wr_dirty : write port, sets valid and
//                    replaces tag and dirty for one set
module l2_tag_store #(
    parameter int INDEX_W = l2_pkg::INDEX_W,
    parameter int TAG_W   = l2_pkg::TAG_W
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [INDEX_W-1:0] i_idx,
    input  logic [TAG_W-1:0]   i_cmp_tag,
    output logic               o_hit,
    output logic               o_valid,
    output logic               o_dirty,
    output logic [TAG_W-1:0]   o_tag,
    input  logic               i_we,
    input  logic [INDEX_W-1:0] i_wr_idx,
    input  logic [TAG_W-1:0]   i_wr_tag,
    input  logic               i_wr_dirty
);
    localparam int SETS = 1 << INDEX_W;

    logic [SETS-1:0]  r_valid;
    logic [SETS-1:0]  r_dirty;
    logic [TAG_W-1:0] r_tag [SETS];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (i_we) begin
            r_valid[i_wr_idx] <= 1'b1;
            r_dirty[i_wr_idx] <= i_wr_dirty;
        end
    end

    // Tag contents are meaningless while valid is clear, so no reset here.
    always_ff @(posedge clk) begin
        if (i_we) r_tag[i_wr_idx] <= i_wr_tag;
    end

    assign o_valid = r_valid[i_idx];
    assign o_dirty = r_dirty[i_idx];
    assign o_tag   = r_tag[i_idx];
    assign o_hit   = r_valid[i_idx] && (r_tag[i_idx] == i_cmp_tag);
endmodule

// File: rtl/l2_cache_ctrl.sv
// l2_cache_ctrl: direct-mapped, write-back, write-allocate L2 controller.
//   L1 side : read_L1_L2/write_L1_L2 level requests with index/tag/line,
//             ready_L2_L1 one-cycle completion pulse with read_data_L2_L1.
//   MEM side: read_L2_MEM (fetch) / write_L2_MEM (victim write-back) with
//             index/tag/line, completed by a ready_MEM_L2 pulse.
// All outputs are registers; hit latency is two cycles from request sample.
module l2_cache_ctrl #(
    parameter int INDEX_W = l2_pkg::INDEX_W,
    parameter int TAG_W   = l2_pkg::TAG_W,
    parameter int LINE_W  = l2_pkg::LINE_W
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               read_L1_L2,
    input  logic               write_L1_L2,
    input  logic [INDEX_W-1:0] index_L1_L2,
    input  logic [TAG_W-1:0]   tag_L1_L2,
    input  logic [LINE_W-1:0]  write_data_L1_L2,
    output logic               ready_L2_L1,
    output logic [LINE_W-1:0]  read_data_L2_L1,
    output logic               read_L2_MEM,
    output logic               write_L2_MEM,
    output logic [INDEX_W-1:0] index_L2_MEM,
    output logic [TAG_W-1:0]   tag_L2_MEM,
    output logic [LINE_W-1:0]  write_data_L2_MEM,
    input  logic               ready_MEM_L2,
    input  logic [LINE_W-1:0]  read_data_MEM_L2
);
    import l2_pkg::*;

    localparam int SETS = 1 << INDEX_W;

    state_t              r_state, w_next;
    logic                r_op_wr;
    logic [INDEX_W-1:0]  r_idx;
    logic [TAG_W-1:0]    r_tag;
    logic [LINE_W-1:0]   r_wdata;
    logic [LINE_W-1:0]   r_data [SETS];

    logic                w_hit, w_valid, w_dirty;
    logic [TAG_W-1:0]    w_vtag;
    logic                w_accept, w_wb_done, w_fill_done;
    logic                w_ts_we, w_ts_dirty;
    logic [TAG_W-1:0]    w_ts_tag;
    logic                w_data_we;
    logic [LINE_W-1:0]   w_data_wr;
    logic [LINE_W-1:0]   w_fill_line;

    l2_tag_store #(.INDEX_W(INDEX_W), .TAG_W(TAG_W)) u_tags (
        .clk        (clk),
        .rstn       (rstn),
        .i_idx      (r_idx),
        .i_cmp_tag  (r_tag),
        .o_hit      (w_hit),
        .o_valid    (w_valid),
        .o_dirty    (w_dirty),
        .o_tag      (w_vtag),
        .i_we       (w_ts_we),
        .i_wr_idx   (r_idx),
        .i_wr_tag   (w_ts_tag),
        .i_wr_dirty (w_ts_dirty)
    );

    // ready_L2_L1 is high in the IDLE cycle after completion while L1 still
    // holds its request; accepting then would replay the finished request.
    assign w_accept    = (read_L1_L2 || write_L1_L2) && !ready_L2_L1;
    // Memory completion only counts while our own request line is up.
    assign w_wb_done   = write_L2_MEM && ready_MEM_L2;
    assign w_fill_done = read_L2_MEM && ready_MEM_L2;
    assign w_fill_line = r_op_wr ? r_wdata : read_data_MEM_L2;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_ts_we    = 1'b0;
        w_ts_tag   = r_tag;
        w_ts_dirty = 1'b0;
        w_data_we  = 1'b0;
        w_data_wr  = r_wdata;
        case (r_state)
            IDLE:    if (w_accept) w_next = COMPARE;
            COMPARE: begin
                if (w_hit) begin
                    w_next = IDLE;
                    if (r_op_wr) begin
                        w_ts_we    = 1'b1;
                        w_ts_dirty = 1'b1;
                        w_data_we  = 1'b1;
                    end
                end else if (w_valid && w_dirty) begin
                    w_next = WRITE_BACK;
                end else begin
                    w_next = ALLOCATE;
                end
            end
            WRITE_BACK: if (w_wb_done) begin
                // Victim is clean in memory now; keep its tag until the fill.
                w_next     = ALLOCATE;
                w_ts_we    = 1'b1;
                w_ts_tag   = w_vtag;
                w_ts_dirty = 1'b0;
            end
            ALLOCATE: if (w_fill_done) begin
                w_next     = RESPOND;
                w_ts_we    = 1'b1;
                w_ts_dirty = r_op_wr;
                w_data_we  = 1'b1;
                w_data_wr  = w_fill_line;
            end
            RESPOND: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_data_we) r_data[r_idx] <= w_data_wr;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_op_wr           <= 1'b0;
            r_idx             <= '0;
            r_tag             <= '0;
            r_wdata           <= '0;
            ready_L2_L1       <= 1'b0;
            read_data_L2_L1   <= '0;
            read_L2_MEM       <= 1'b0;
            write_L2_MEM      <= 1'b0;
            index_L2_MEM      <= '0;
            tag_L2_MEM        <= '0;
            write_data_L2_MEM <= '0;
        end else begin
            ready_L2_L1 <= 1'b0;
            case (r_state)
                IDLE: if (w_accept) begin
                    r_op_wr <= write_L1_L2;
                    r_idx   <= index_L1_L2;
                    r_tag   <= tag_L1_L2;
                    r_wdata <= write_data_L1_L2;
                end
                COMPARE: begin
                    if (w_hit) begin
                        ready_L2_L1 <= 1'b1;
                        if (!r_op_wr) read_data_L2_L1 <= r_data[r_idx];
                    end else if (w_valid && w_dirty) begin
                        write_L2_MEM      <= 1'b1;
                        index_L2_MEM      <= r_idx;
                        tag_L2_MEM        <= w_vtag;
                        write_data_L2_MEM <= r_data[r_idx];
                    end
                end
                WRITE_BACK: if (w_wb_done) write_L2_MEM <= 1'b0;
                ALLOCATE: begin
                    // First ALLOCATE cycle has both request lines low, which
                    // gives the idle gap after a write-back.
                    if (w_fill_done) begin
                        read_L2_MEM     <= 1'b0;
                        read_data_L2_L1 <= w_fill_line;
                    end else begin
                        read_L2_MEM  <= 1'b1;
                        index_L2_MEM <= r_idx;
                        tag_L2_MEM   <= r_tag;
                    end
                end
                RESPOND: ready_L2_L1 <= 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_l2_cache_ctrl.sv
// tb_l2_cache_ctrl: directed test of l2_cache_ctrl with a small memory
// responder (fixed latency, backing store of written-back lines).
module tb_l2_cache_ctrl;
    import l2_pkg::*;

    localparam int MEM_LAT = 2;

    logic               clk = 1'b0;
    logic               rstn;
    logic               read_L1_L2, write_L1_L2;
    logic [INDEX_W-1:0] index_L1_L2;
    logic [TAG_W-1:0]   tag_L1_L2;
    logic [LINE_W-1:0]  write_data_L1_L2;
    logic               ready_L2_L1;
    logic [LINE_W-1:0]  read_data_L2_L1;
    logic               read_L2_MEM, write_L2_MEM;
    logic [INDEX_W-1:0] index_L2_MEM;
    logic [TAG_W-1:0]   tag_L2_MEM;
    logic [LINE_W-1:0]  write_data_L2_MEM;
    logic               ready_MEM_L2;
    logic [LINE_W-1:0]  read_data_MEM_L2;

    int n_cmp = 0;
    int n_err = 0;

    // memory responder bookkeeping
    logic               mem_stall = 1'b0;
    logic [LINE_W-1:0]  mem [logic [INDEX_W+TAG_W-1:0]];
    int                 rd_cnt = 0, wr_cnt = 0, mem_seq = 0, rd_seq = 0, wr_seq = 0;
    logic [TAG_W-1:0]   last_rd_tag, last_wr_tag;
    logic [INDEX_W-1:0] last_rd_idx, last_wr_idx;
    logic [LINE_W-1:0]  last_wr_data;

    // protocol monitor
    int   viol_both = 0, viol_gap = 0;
    logic prev_rd = 1'b0, prev_wr = 1'b0;

    l2_cache_ctrl dut (
        .clk               (clk),
        .rstn              (rstn),
        .read_L1_L2        (read_L1_L2),
        .write_L1_L2       (write_L1_L2),
        .index_L1_L2       (index_L1_L2),
        .tag_L1_L2         (tag_L1_L2),
        .write_data_L1_L2  (write_data_L1_L2),
        .ready_L2_L1       (ready_L2_L1),
        .read_data_L2_L1   (read_data_L2_L1),
        .read_L2_MEM       (read_L2_MEM),
        .write_L2_MEM      (write_L2_MEM),
        .index_L2_MEM      (index_L2_MEM),
        .tag_L2_MEM        (tag_L2_MEM),
        .write_data_L2_MEM (write_data_L2_MEM),
        .ready_MEM_L2      (ready_MEM_L2),
        .read_data_MEM_L2  (read_data_MEM_L2)
    );

    always #5 clk = ~clk;

    function automatic logic [LINE_W-1:0] mem_pat(input logic [TAG_W-1:0] t, input logic [INDEX_W-1:0] i);
        logic [LINE_W-1:0] l;
        l = '0;
        for (int w = 0; w < LINE_W / WORD_W; w++)
            l[w*WORD_W +: WORD_W] = {4'hC, w[3:0], i, t[15:0]};
        return l;
    endfunction

    initial begin
        logic [INDEX_W+TAG_W-1:0] key;
        int lat_cnt;
        lat_cnt = 0;
        ready_MEM_L2 = 1'b0;
        read_data_MEM_L2 = '0;
        forever begin
            @(posedge clk); #1;
            ready_MEM_L2 = 1'b0;
            if (rstn && !mem_stall && (read_L2_MEM || write_L2_MEM)) begin
                if (lat_cnt == MEM_LAT) begin
                    lat_cnt = 0;
                    ready_MEM_L2 = 1'b1;
                    mem_seq++;
                    key = {tag_L2_MEM, index_L2_MEM};
                    if (write_L2_MEM) begin
                        mem[key] = write_data_L2_MEM;
                        wr_cnt++;
                        wr_seq = mem_seq;
                        last_wr_tag = tag_L2_MEM;
                        last_wr_idx = index_L2_MEM;
                        last_wr_data = write_data_L2_MEM;
                    end else begin
                        read_data_MEM_L2 = mem.exists(key) ? mem[key] : mem_pat(tag_L2_MEM, index_L2_MEM);
                        rd_cnt++;
                        rd_seq = mem_seq;
                        last_rd_tag = tag_L2_MEM;
                        last_rd_idx = index_L2_MEM;
                    end
                end else begin
                    lat_cnt++;
                end
            end else begin
                lat_cnt = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (read_L2_MEM && write_L2_MEM) viol_both++;
        if ((read_L2_MEM && prev_wr) || (write_L2_MEM && prev_rd)) viol_gap++;
        prev_rd = read_L2_MEM;
        prev_wr = write_L2_MEM;
    end

    // Drive one L1 request, wait (bounded) for ready, return cycles and data.
    task automatic do_req(input logic wr, input logic rd, input logic [INDEX_W-1:0] idx,
                          input logic [TAG_W-1:0] t, input logic [LINE_W-1:0] wd,
                          output int cyc, output logic [LINE_W-1:0] rdata);
        logic got;
        got = 1'b0;
        rdata = '0;
        cyc = 0;
        @(posedge clk); #1;
        read_L1_L2 = rd; write_L1_L2 = wr;
        index_L1_L2 = idx; tag_L1_L2 = t; write_data_L1_L2 = wd;
        while (!got && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            if (ready_L2_L1) begin
                got = 1'b1;
                rdata = read_data_L2_L1;
            end
        end
        read_L1_L2 = 1'b0; write_L1_L2 = 1'b0;
        if (!got) begin
            n_cmp++; n_err++;
            $display("FAIL req_timeout: no ready_L2_L1 within %0d cycles (idx %h tag %h)", cyc, idx, t);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        read_L1_L2 = 1'b0; write_L1_L2 = 1'b0;
        index_L1_L2 = '0; tag_L1_L2 = '0; write_data_L1_L2 = '0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (ready_L2_L1 !== 1'b0)      begin n_err++; $display("FAIL rst_ready: got %b want 0", ready_L2_L1); end
        n_cmp++; if (read_L2_MEM !== 1'b0)      begin n_err++; $display("FAIL rst_read_mem: got %b want 0", read_L2_MEM); end
        n_cmp++; if (write_L2_MEM !== 1'b0)     begin n_err++; $display("FAIL rst_write_mem: got %b want 0", write_L2_MEM); end
        n_cmp++; if (read_data_L2_L1 !== '0)    begin n_err++; $display("FAIL rst_rdata: got %h want 0", read_data_L2_L1); end
        n_cmp++; if (index_L2_MEM !== '0)       begin n_err++; $display("FAIL rst_index_mem: got %h want 0", index_L2_MEM); end
        n_cmp++; if (tag_L2_MEM !== '0)         begin n_err++; $display("FAIL rst_tag_mem: got %h want 0", tag_L2_MEM); end
        n_cmp++; if (write_data_L2_MEM !== '0)  begin n_err++; $display("FAIL rst_wdata_mem: got %h want 0", write_data_L2_MEM); end
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_cold_read();
        int cyc, rd0, wr0;
        logic [LINE_W-1:0] rdata;
        rd0 = rd_cnt; wr0 = wr_cnt;
        do_req(1'b0, 1'b1, 8'h03, 18'h0, '0, cyc, rdata);
        n_cmp++; if (rdata !== mem_pat(18'h0, 8'h03)) begin n_err++; $display("FAIL cold_rdata: got %h want %h", rdata, mem_pat(18'h0, 8'h03)); end
        n_cmp++; if (rd_cnt - rd0 !== 1) begin n_err++; $display("FAIL cold_fills: got %0d want 1", rd_cnt - rd0); end
        n_cmp++; if (wr_cnt - wr0 !== 0) begin n_err++; $display("FAIL cold_writebacks: got %0d want 0", wr_cnt - wr0); end
        n_cmp++; if (last_rd_tag !== 18'h0 || last_rd_idx !== 8'h03) begin n_err++; $display("FAIL cold_fill_addr: got tag %h idx %h want 0/03", last_rd_tag, last_rd_idx); end
        n_cmp++; if (cyc <= 2) begin n_err++; $display("FAIL cold_latency: got %0d want >2", cyc); end
    endtask

    task automatic test_read_hit();
        int cyc, rd0, wr0;
        logic [LINE_W-1:0] rdata;
        rd0 = rd_cnt; wr0 = wr_cnt;
        do_req(1'b0, 1'b1, 8'h03, 18'h0, '0, cyc, rdata);
        n_cmp++; if (cyc !== 2) begin n_err++; $display("FAIL hit_latency: got %0d want 2", cyc); end
        n_cmp++; if (rdata !== mem_pat(18'h0, 8'h03)) begin n_err++; $display("FAIL hit_rdata: got %h want %h", rdata, mem_pat(18'h0, 8'h03)); end
        n_cmp++; if (rd_cnt - rd0 !== 0 || wr_cnt - wr0 !== 0) begin n_err++; $display("FAIL hit_mem_traffic: got rd %0d wr %0d want 0/0", rd_cnt - rd0, wr_cnt - wr0); end
        @(posedge clk); #1;
        n_cmp++; if (ready_L2_L1 !== 1'b0) begin n_err++; $display("FAIL hit_ready_pulse: got %b want 0", ready_L2_L1); end
    endtask

    task automatic test_write_hit_conflict();
        int cyc, rd0, wr0;
        logic [LINE_W-1:0] rdata, a5;
        a5 = {16{32'hA5A5_A5A5}};
        rd0 = rd_cnt; wr0 = wr_cnt;
        do_req(1'b1, 1'b0, 8'h03, 18'h0, a5, cyc, rdata);
        n_cmp++; if (cyc !== 2) begin n_err++; $display("FAIL whit_latency: got %0d want 2", cyc); end
        n_cmp++; if (rd_cnt - rd0 !== 0 || wr_cnt - wr0 !== 0) begin n_err++; $display("FAIL whit_mem_traffic: got rd %0d wr %0d want 0/0", rd_cnt - rd0, wr_cnt - wr0); end
        do_req(1'b0, 1'b1, 8'h03, 18'h1, '0, cyc, rdata);
        n_cmp++; if (wr_cnt - wr0 !== 1) begin n_err++; $display("FAIL conf_writebacks: got %0d want 1", wr_cnt - wr0); end
        n_cmp++; if (last_wr_tag !== 18'h0 || last_wr_idx !== 8'h03) begin n_err++; $display("FAIL conf_wb_addr: got tag %h idx %h want 0/03", last_wr_tag, last_wr_idx); end
        n_cmp++; if (last_wr_data !== a5) begin n_err++; $display("FAIL conf_wb_data: got %h want %h", last_wr_data, a5); end
        n_cmp++; if (rd_cnt - rd0 !== 1) begin n_err++; $display("FAIL conf_fills: got %0d want 1", rd_cnt - rd0); end
        n_cmp++; if (last_rd_tag !== 18'h1) begin n_err++; $display("FAIL conf_fill_tag: got %h want 1", last_rd_tag); end
        n_cmp++; if (!(wr_seq < rd_seq)) begin n_err++; $display("FAIL conf_order: got wr_seq %0d rd_seq %0d want wr first", wr_seq, rd_seq); end
        n_cmp++; if (rdata !== mem_pat(18'h1, 8'h03)) begin n_err++; $display("FAIL conf_rdata: got %h want %h", rdata, mem_pat(18'h1, 8'h03)); end
        n_cmp++; if (viol_gap !== 0 || viol_both !== 0) begin n_err++; $display("FAIL mem_handshake: got gap %0d both %0d want 0/0", viol_gap, viol_both); end
    endtask

    task automatic test_write_miss_alloc();
        int cyc, rd0, wr0;
        logic [LINE_W-1:0] rdata, wl;
        wl = {8{64'h0123_4567_89AB_CDEF}};
        rd0 = rd_cnt; wr0 = wr_cnt;
        do_req(1'b1, 1'b0, 8'h10, 18'h2, wl, cyc, rdata);
        n_cmp++; if (rd_cnt - rd0 !== 1 || wr_cnt - wr0 !== 0) begin n_err++; $display("FAIL walloc_traffic: got rd %0d wr %0d want 1/0", rd_cnt - rd0, wr_cnt - wr0); end
        n_cmp++; if (last_rd_tag !== 18'h2 || last_rd_idx !== 8'h10) begin n_err++; $display("FAIL walloc_fill_addr: got tag %h idx %h want 2/10", last_rd_tag, last_rd_idx); end
        n_cmp++; if (rdata !== wl) begin n_err++; $display("FAIL walloc_resp_data: got %h want %h", rdata, wl); end
        rd0 = rd_cnt;
        do_req(1'b0, 1'b1, 8'h10, 18'h2, '0, cyc, rdata);
        n_cmp++; if (rdata !== wl) begin n_err++; $display("FAIL walloc_readback: got %h want %h", rdata, wl); end
        n_cmp++; if (cyc !== 2 || rd_cnt - rd0 !== 0) begin n_err++; $display("FAIL walloc_readback_hit: got cyc %0d fills %0d want 2/0", cyc, rd_cnt - rd0); end
    endtask

    task automatic test_simultaneous();
        int cyc;
        logic [LINE_W-1:0] rdata, sl;
        sl = {16{32'h5A5A_0F0F}};
        do_req(1'b1, 1'b1, 8'h20, 18'h5, sl, cyc, rdata);
        do_req(1'b0, 1'b1, 8'h20, 18'h5, '0, cyc, rdata);
        n_cmp++; if (rdata !== sl) begin n_err++; $display("FAIL simul_write_prio: got %h want %h", rdata, sl); end
        n_cmp++; if (cyc !== 2) begin n_err++; $display("FAIL simul_readback_latency: got %0d want 2", cyc); end
    endtask

    task automatic test_reset_during_alloc();
        int cyc, wait_cyc, rd0, wr0;
        logic [LINE_W-1:0] rdata;
        mem_stall = 1'b1;
        @(posedge clk); #1;
        read_L1_L2 = 1'b1; index_L1_L2 = 8'h30; tag_L1_L2 = 18'h7;
        wait_cyc = 0;
        while (read_L2_MEM !== 1'b1 && wait_cyc < 20) begin
            @(posedge clk); #1;
            wait_cyc++;
        end
        n_cmp++; if (read_L2_MEM !== 1'b1) begin n_err++; $display("FAIL arst_fetch_seen: got %b want 1", read_L2_MEM); end
        @(negedge clk); #1;
        rstn = 1'b0;
        #1;
        n_cmp++; if (read_L2_MEM !== 1'b0) begin n_err++; $display("FAIL arst_read_drop: got %b want 0", read_L2_MEM); end
        n_cmp++; if (tag_L2_MEM !== '0 || index_L2_MEM !== '0) begin n_err++; $display("FAIL arst_addr_clear: got tag %h idx %h want 0/0", tag_L2_MEM, index_L2_MEM); end
        read_L1_L2 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        mem_stall = 1'b0;
        rd0 = rd_cnt; wr0 = wr_cnt;
        do_req(1'b0, 1'b1, 8'h10, 18'h2, '0, cyc, rdata);
        n_cmp++; if (rd_cnt - rd0 !== 1 || wr_cnt - wr0 !== 0) begin n_err++; $display("FAIL arst_miss_traffic: got rd %0d wr %0d want 1/0", rd_cnt - rd0, wr_cnt - wr0); end
        n_cmp++; if (rdata !== mem_pat(18'h2, 8'h10)) begin n_err++; $display("FAIL arst_miss_data: got %h want %h", rdata, mem_pat(18'h2, 8'h10)); end
    endtask

    initial begin
        test_reset();
        test_cold_read();
        test_read_hit();
        test_write_hit_conflict();
        test_write_miss_alloc();
        test_simultaneous();
        test_reset_during_alloc();
        n_cmp++; if (viol_both !== 0) begin n_err++; $display("FAIL mem_both_high: got %0d want 0", viol_both); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got %0d compared %0d mismatched", n_cmp, n_err);
        $fatal(1, "timeout");
    end
endmodule
